// File: rtl/stopwatch_timer.sv
// stopwatch_timer
//   Start/stop elapsed counter that wraps from MAX back to 0.
//   A single sampled start pulse arms the counter. Counting then
//   continues on every edge until stop or reset.
//
// Parameters
//   MAX    terminal count, 1..65535. The edge after count reaches MAX
//          returns count to 0.
//
// Ports
//   clk    clock; all state updates on the rising edge
//   reset  synchronous active-low reset (count=0, IDLE)
//   start  run request, level-sampled (one-shot trigger)
//   stop   halt request, level-sampled; overrides start
//   count  elapsed count, driven straight from a register
module stopwatch_timer #(
  parameter int unsigned MAX = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] count
);

  localparam logic [15:0] MAX_C = 16'(MAX);

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_e;

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        inc;

  // The increment happens on the same edge that samples start, which
  // gives zero latency. Holding start while RUNNING is the same as one
  // increment, so no double step can occur.
  assign inc = !stop && (start || (state_q == RUNNING));

  // Wrap to 0 instead of passing MAX. Because of this, the bits above
  // the width of MAX never become set.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = (count_q == MAX_C) ? 16'd0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 16'd0;
    end else if (stop) begin
      // Halt and keep the count, so a later start resumes from it.
      state_q <= IDLE;
    end else if (inc) begin
      state_q <= RUNNING;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
module tb_stopwatch_timer;

  logic        clk = 1'b0;
  logic        r99, s99, p99;
  logic        r3, s3, p3;
  logic [15:0] cnt99, cnt3;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    bit          sel;   // 0: MAX=99 instance, 1: MAX=3 instance
    logic [15:0] exp;
  } sb_t;

  sb_t sbq[$];

  // Reference model state for the random phase.
  int  m_cnt;
  bit  m_run;

  always #5 clk = ~clk;

  stopwatch_timer #(.MAX(99)) u_dut99 (
    .clk   (clk),
    .reset (r99),
    .start (s99),
    .stop  (p99),
    .count (cnt99)
  );

  stopwatch_timer #(.MAX(3)) u_dut3 (
    .clk   (clk),
    .reset (r3),
    .start (s3),
    .stop  (p3),
    .count (cnt3)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit sel, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  // Advance one edge, then compare everything queued for that edge.
  task automatic edge_chk();
    sb_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, e.sel ? cnt3 : cnt99, e.exp);
    end
  endtask

  task automatic drv99(input logic r, input logic s, input logic p,
                       input logic [15:0] exp, input string tag);
    r99 = r; s99 = s; p99 = p;
    push(tag, 1'b0, exp);
    edge_chk();
  endtask

  task automatic drv3(input logic r, input logic s, input logic p,
                      input logic [15:0] exp, input string tag);
    r3 = r; s3 = s; p3 = p;
    push(tag, 1'b1, exp);
    edge_chk();
  endtask

  initial begin
    // Reset both instances with start and stop also high.
    r99 = 1'b0; s99 = 1'b1; p99 = 1'b1;
    r3  = 1'b0; s3  = 1'b1; p3  = 1'b1;
    push("rst99", 1'b0, 16'd0);
    push("rst3",  1'b1, 16'd0);
    edge_chk();
    r3 = 1'b1; s3 = 1'b0; p3 = 1'b0;
    for (int i = 0; i < 3; i++) drv99(1'b1, 1'b0, 1'b0, 16'd0, "rst_idle");

    // Start held for 5 edges, then released: counting continues.
    for (int i = 1; i <= 5; i++) drv99(1'b1, 1'b1, 1'b0, 16'(i), "start_run");
    drv99(1'b1, 1'b0, 1'b0, 16'd6, "run_free");

    // Stop for 2 edges, then idle: the count holds, and a restart continues.
    drv99(1'b1, 1'b0, 1'b1, 16'd6, "stop_hold");
    drv99(1'b1, 1'b0, 1'b1, 16'd6, "stop_hold");
    drv99(1'b1, 1'b0, 1'b0, 16'd6, "stop_idle");
    drv99(1'b1, 1'b1, 1'b0, 16'd7, "resume");
    drv99(1'b1, 1'b0, 1'b0, 16'd8, "resume");
    drv99(1'b1, 1'b0, 1'b0, 16'd9, "resume");

    // start and stop together: the count is unchanged and the block goes IDLE.
    drv99(1'b1, 1'b1, 1'b1, 16'd9, "simul");
    drv99(1'b1, 1'b0, 1'b0, 16'd9, "simul_idle");
    // stop while IDLE has no effect.
    drv99(1'b1, 1'b0, 1'b1, 16'd9, "stop_in_idle");
    drv99(1'b1, 1'b0, 1'b0, 16'd9, "stop_in_idle");

    // Run to 40, then reset mid-count.
    drv99(1'b1, 1'b1, 1'b0, 16'd10, "to40");
    for (int i = 11; i <= 40; i++) drv99(1'b1, 1'b0, 1'b0, 16'(i), "to40");
    drv99(1'b0, 1'b0, 1'b0, 16'd0, "rst_mid");
    for (int i = 0; i < 3; i++) drv99(1'b1, 1'b0, 1'b0, 16'd0, "rst_mid_idle");
    // start high on the first edge after reset release counts immediately.
    drv99(1'b0, 1'b1, 1'b0, 16'd0, "rst_w_start");
    drv99(1'b1, 1'b1, 1'b0, 16'd1, "release_start");
    drv99(1'b1, 1'b0, 1'b1, 16'd1, "halt");

    // Wrap with MAX=3. The upper bits must stay zero.
    drv3(1'b1, 1'b1, 1'b0, 16'd1, "wrap");
    drv3(1'b1, 1'b0, 1'b0, 16'd2, "wrap");
    drv3(1'b1, 1'b0, 1'b0, 16'd3, "wrap");
    drv3(1'b1, 1'b0, 1'b0, 16'd0, "wrap");
    drv3(1'b1, 1'b0, 1'b0, 16'd1, "wrap");
    drv3(1'b1, 1'b0, 1'b1, 16'd1, "wrap_stop");

    // Random stretch on MAX=99 against a behavioural model. Stop is rare,
    // so the count reaches the wrap point.
    m_cnt = 1;
    m_run = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic r, s, p;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 29) == 0);
      if (!r) begin
        m_cnt = 0;
        m_run = 1'b0;
      end else if (p) begin
        m_run = 1'b0;
      end else if (s || m_run) begin
        m_run = 1'b1;
        m_cnt = (m_cnt == 99) ? 0 : m_cnt + 1;
      end
      drv99(r, s, p, 16'(m_cnt), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
